// File: rtl/day3_joltage_engine.sv
// Streaming joltage engine: per-lane largest-K-digit subsequence, decimal-to-binary
// conversion, pipelined adder-tree reduction. Define DAY3_RUNNING_TOTAL_EN to accumulate joltage_sum.
module day3_joltage_engine #(
  parameter int NUM_UNITS            = 4,
  parameter int NUM_ACTIVE_BATTERIES = 12,
  parameter int MAX_PACK_LEN         = 128,
  parameter int LEN_W                = $clog2(MAX_PACK_LEN + 1),
  parameter int LANE_W               = (7 * NUM_ACTIVE_BATTERIES + 1) / 2,
  parameter int SUM_W                = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_UNITS-1:0][LEN_W-1:0] pack_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_UNITS-1:0][3:0]      digits,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [SUM_W-1:0]               joltage_sum,
  output logic                           busy,
  output logic                           digit_err
);
  localparam int K    = NUM_ACTIVE_BATTERIES;
  localparam int SZ_W = $clog2(K + 1);
  localparam int S    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int P    = 1 << S;
  localparam int RC_W = $clog2(S + 1);

  typedef enum logic [2:0] {IDLE, STREAM, CONVERT, REDUCE, DONE} state_t;

  state_t            state_reg;
  logic [LEN_W-1:0]  beat_cnt_reg;
  logic [LEN_W-1:0]  max_len_reg;
  logic [LEN_W-1:0]  max_len_next;
  logic [SZ_W-1:0]   conv_idx_reg;
  logic [RC_W-1:0]   red_cnt_reg;
  logic              in_ready_reg;
  logic              result_valid_reg;
  logic              busy_reg;
  logic              digit_err_reg;
  logic [SUM_W-1:0]  joltage_sum_reg;

  logic              start_fire;
  logic              beat_fire;
  logic              conv_step;
  logic [NUM_UNITS-1:0] lane_bad;
  logic [LANE_W-1:0] lane_acc [NUM_UNITS];
  logic [SUM_W-1:0]  tree_in  [P];
  logic [SUM_W-1:0]  tree_reg [S][P/2];

  assign start_fire = (state_reg == IDLE) && start;
  assign beat_fire  = in_ready_reg && in_valid;
  assign conv_step  = (state_reg == CONVERT);

  always_comb begin
    max_len_next = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (pack_len[i] > max_len_next) max_len_next = pack_len[i];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_lane
      logic [3:0]        stack_reg [K];
      logic [SZ_W-1:0]   size_reg;
      logic [LANE_W-1:0] acc_reg;
      logic [LEN_W-1:0]  len_reg;
      logic [3:0]        digit_in;
      logic [3:0]        conv_digit;
      logic              active;
      int                rem_i, lo_i, size_i, pos_i;

      // Monotone stack insert: the lowest slot >= lo holding a smaller digit is
      // overwritten (implicitly popping everything above it), else append.
      always_comb begin
        active   = beat_cnt_reg < len_reg;
        digit_in = (digits[gi] > 4'd9) ? 4'd0 : digits[gi];
        rem_i    = int'(len_reg) - int'(beat_cnt_reg);
        lo_i     = (K > rem_i) ? K - rem_i : 0;
        size_i   = int'(size_reg);
        pos_i    = size_i;
        for (int j = K - 1; j >= 0; j--)
          if (j >= lo_i && j < size_i && stack_reg[j] < digit_in) pos_i = j;
        conv_digit = '0;
        for (int j = 0; j < K; j++)
          if (j == int'(conv_idx_reg)) conv_digit = stack_reg[j];
      end

      assign lane_bad[gi] = active && (digits[gi] > 4'd9);
      assign lane_acc[gi] = acc_reg;

      always_ff @(posedge clock) begin
        if (!reset) begin
          len_reg  <= '0;
          size_reg <= '0;
          acc_reg  <= '0;
        end else if (start_fire) begin
          len_reg  <= pack_len[gi];
          size_reg <= '0;
          acc_reg  <= '0;
        end else if (beat_fire && active && pos_i < K) begin
          for (int j = 0; j < K; j++)
            if (j == pos_i) stack_reg[j] <= digit_in;
          size_reg <= SZ_W'(pos_i + 1);
        end else if (conv_step && conv_idx_reg < size_reg) begin
          acc_reg <= acc_reg * LANE_W'(10) + LANE_W'(conv_digit);
        end
      end
    end

    for (gi = 0; gi < P; gi++) begin : g_tree_in
      if (gi < NUM_UNITS) begin : g_used
        assign tree_in[gi] = SUM_W'(lane_acc[gi]);
      end else begin : g_pad
        assign tree_in[gi] = '0;
      end
    end
  endgenerate

  // Free-running tree; the FSM just waits S cycles for it to settle.
  always_ff @(posedge clock) begin
    for (int i = 0; i < P / 2; i++)
      tree_reg[0][i] <= tree_in[2*i] + tree_in[2*i+1];
    for (int lv = 1; lv < S; lv++)
      for (int i = 0; i < (P >> (lv + 1)); i++)
        tree_reg[lv][i] <= tree_reg[lv-1][2*i] + tree_reg[lv-1][2*i+1];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg        <= IDLE;
      beat_cnt_reg     <= '0;
      max_len_reg      <= '0;
      conv_idx_reg     <= '0;
      red_cnt_reg      <= '0;
      in_ready_reg     <= 1'b0;
      result_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      digit_err_reg    <= 1'b0;
      joltage_sum_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          max_len_reg   <= max_len_next;
          beat_cnt_reg  <= '0;
          conv_idx_reg  <= '0;
          digit_err_reg <= 1'b0;
          busy_reg      <= 1'b1;
          if (max_len_next == '0) begin
            state_reg <= CONVERT;
          end else begin
            state_reg    <= STREAM;
            in_ready_reg <= 1'b1;
          end
        end
        STREAM: if (beat_fire) begin
          if (|lane_bad) digit_err_reg <= 1'b1;
          beat_cnt_reg <= beat_cnt_reg + 1'b1;
          if (beat_cnt_reg == max_len_reg - 1'b1) begin
            state_reg    <= CONVERT;
            in_ready_reg <= 1'b0;
          end
        end
        CONVERT: begin
          conv_idx_reg <= conv_idx_reg + 1'b1;
          if (conv_idx_reg == SZ_W'(K - 1)) begin
            state_reg   <= REDUCE;
            red_cnt_reg <= '0;
          end
        end
        REDUCE: begin
          red_cnt_reg <= red_cnt_reg + 1'b1;
          if (red_cnt_reg == RC_W'(S - 1)) state_reg <= DONE;
        end
        DONE: begin
          if (!result_valid_reg) begin
            result_valid_reg <= 1'b1;
`ifdef DAY3_RUNNING_TOTAL_EN
            joltage_sum_reg  <= joltage_sum_reg + tree_reg[S-1][0];
`else
            joltage_sum_reg  <= tree_reg[S-1][0];
`endif
          end else if (result_ready) begin
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            state_reg        <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_reg;
  assign result_valid = result_valid_reg;
  assign joltage_sum  = joltage_sum_reg;
  assign busy         = busy_reg;
  assign digit_err    = digit_err_reg;

endmodule

// File: tb/tb_day3_joltage_engine.sv
// Directed bench: a K=12 and a K=2 engine share one stimulus stream; sums,
// latency, stall stability, digit errors and mid-batch reset are checked.
module tb_day3_joltage_engine;
  localparam int NU = 4;
  localparam int LW = 8;
  localparam logic [63:0] PK0 = 64'h987654321111111;
  localparam logic [63:0] PK1 = 64'h811111111111119;
  localparam logic [63:0] PK2 = 64'h234234234234278;
  localparam logic [63:0] PK3 = 64'h818181911112111;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic result_ready = 1'b0;
  logic [NU-1:0][LW-1:0] pack_len = '0;
  logic [NU-1:0][3:0]    digits = '0;

  logic in_ready_a, result_valid_a, busy_a, digit_err_a;
  logic in_ready_b, result_valid_b, busy_b, digit_err_b;
  logic [63:0] sum_a, sum_b;

  int checks = 0;
  int failures = 0;
  logic [63:0] pk [NU];
  int          lens_tb [NU];
  logic [63:0] total_a = '0;
  logic [63:0] total_b = '0;

  always #5 clock = ~clock;

  day3_joltage_engine dut_k12 (
    .clock(clock), .reset(reset), .start(start), .pack_len(pack_len),
    .in_valid(in_valid), .in_ready(in_ready_a), .digits(digits),
    .result_valid(result_valid_a), .result_ready(result_ready),
    .joltage_sum(sum_a), .busy(busy_a), .digit_err(digit_err_a)
  );

  day3_joltage_engine #(.NUM_ACTIVE_BATTERIES(2)) dut_k2 (
    .clock(clock), .reset(reset), .start(start), .pack_len(pack_len),
    .in_valid(in_valid), .in_ready(in_ready_b), .digits(digits),
    .result_valid(result_valid_b), .result_ready(result_ready),
    .joltage_sum(sum_b), .busy(busy_b), .digit_err(digit_err_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] next_total(input logic [63:0] prev, input logic [63:0] batch);
`ifdef DAY3_RUNNING_TOTAL_EN
    return prev + batch;
`else
    return batch;
`endif
  endfunction

  function automatic logic [3:0] lane_digit(input int l, input int b);
    logic [63:0] v;
    v = pk[l];
    if (b < lens_tb[l]) return v[(lens_tb[l] - 1 - b) * 4 +: 4];
    return 4'h9;
  endfunction

  task automatic setup(input logic [63:0] p0, p1, p2, p3, input int l0, l1, l2, l3);
    pk[0] = p0; pk[1] = p1; pk[2] = p2; pk[3] = p3;
    lens_tb[0] = l0; lens_tb[1] = l1; lens_tb[2] = l2; lens_tb[3] = l3;
  endtask

  task automatic start_batch(input string tag);
    for (int l = 0; l < NU; l++) pack_len[l] = LW'(lens_tb[l]);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy_a), 64'd1);
  endtask

  task automatic stream(input string tag, input bit stall, input int err_lane, input int err_beat);
    int b, cyc, mx;
    bit fire;
    b = 0; cyc = 0; mx = 0;
    for (int l = 0; l < NU; l++) if (lens_tb[l] > mx) mx = lens_tb[l];
    check({tag, "_in_ready"}, 64'(in_ready_a), 64'd1);
    while (b < mx) begin
      for (int l = 0; l < NU; l++)
        digits[l] = (l == err_lane && b == err_beat) ? 4'hC : lane_digit(l, b);
      in_valid = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      fire = in_valid && in_ready_a;
      step();
      if (fire) b++;
      cyc++;
      if (cyc > 1000) begin
        check({tag, "_stream_timeout"}, 64'(b), 64'(mx));
        break;
      end
    end
    in_valid = 1'b0;
    digits = '0;
  endtask

  task automatic finish_batch(input string tag, input logic [63:0] exp_a, input logic [63:0] exp_b,
                              input int hold);
    int lat_a, lat_b;
    logic [63:0] held;
    lat_a = -1; lat_b = -1;
    check({tag, "_in_ready_off"}, 64'(in_ready_a), 64'd0);
    for (int k = 0; k < 100 && (lat_a < 0 || lat_b < 0); k++) begin
      if (result_valid_a && lat_a < 0) lat_a = k;
      if (result_valid_b && lat_b < 0) lat_b = k;
      if (lat_a < 0 || lat_b < 0) step();
    end
    check({tag, "_lat_k12"}, 64'(lat_a), 64'd15);
    check({tag, "_lat_k2"}, 64'(lat_b), 64'd5);
    total_a = next_total(total_a, exp_a);
    total_b = next_total(total_b, exp_b);
    check({tag, "_sum_k12"}, sum_a, total_a);
    check({tag, "_sum_k2"}, sum_b, total_b);
    check({tag, "_digit_err"}, 64'(digit_err_a), 64'd0);
    held = sum_a;
    for (int h = 0; h < hold; h++) begin
      start = (h < hold - 1);
      step();
      check({tag, "_hold_valid"}, 64'(result_valid_a), 64'd1);
      check({tag, "_hold_sum"}, sum_a, held);
    end
    start = 1'b0;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(result_valid_a), 64'd0);
    check({tag, "_idle_k12"}, 64'(busy_a), 64'd0);
    check({tag, "_idle_k2"}, 64'(busy_b), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    step();
    step();
    check("rst_in_ready", 64'(in_ready_a), 64'd0);
    check("rst_valid", 64'(result_valid_a), 64'd0);
    check("rst_sum", sum_a, 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_digit_err", 64'(digit_err_b), 64'd0);
    reset = 1'b1;
    step();

    setup(PK0, PK1, PK2, PK3, 15, 15, 15, 15);
    start_batch("b1");
    stream("b1", 1'b0, -1, -1);
    finish_batch("b1", 64'd3121910778619, 64'd357, 0);

    start_batch("b2");
    stream("b2", 1'b0, -1, -1);
    finish_batch("b2", 64'd3121910778619, 64'd357, 0);

    setup(PK0, 64'h31415, 64'h0, PK2, 15, 5, 0, 15);
    start_batch("short");
    stream("short", 1'b0, -1, -1);
    finish_batch("short", 64'd1421888586804, 64'd221, 0);

    setup(PK0, PK1, PK2, PK3, 15, 15, 15, 15);
    start_batch("stall");
    stream("stall", 1'b1, -1, -1);
    finish_batch("stall", 64'd3121910778619, 64'd357, 5);

    start_batch("err");
    stream("err", 1'b0, 2, 3);
    step(); step(); step(); step();
    check("err_digit_err_k12", 64'(digit_err_a), 64'd1);
    check("err_digit_err_k2", 64'(digit_err_b), 64'd1);
    check("err_busy", 64'(busy_a), 64'd1);
    reset = 1'b0;
    step();
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_valid", 64'(result_valid_a), 64'd0);
    check("abort_sum", sum_a, 64'd0);
    check("abort_digit_err", 64'(digit_err_a), 64'd0);
    check("abort_busy_k2", 64'(busy_b), 64'd0);
    reset = 1'b1;
    total_a = '0;
    total_b = '0;
    step();
    step();
    check("abort_no_result", 64'(result_valid_a), 64'd0);

    start_batch("clean");
    stream("clean", 1'b0, -1, -1);
    finish_batch("clean", 64'd3121910778619, 64'd357, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/day3_joltage_engine.md
Name: day3_joltage_engine

Overview:
- Streaming, parametrised battery-joltage engine. NUM_UNITS lanes each receive one battery pack, one digit per beat.
- Each lane selects the lexicographically largest NUM_ACTIVE_BATTERIES-digit subsequence of its pack and converts it to binary. A pipelined adder tree then reduces all lanes to one joltage sum.
- Generalises the puzzle1 (K=2) and puzzle2 (K=12) datapaths: adds per-lane pack lengths, valid/ready handshakes on input and result, and an explicit control FSM.

Parameters:
- NUM_UNITS, 4, number of parallel lanes (power of two not required).
- NUM_ACTIVE_BATTERIES, 12, K: digits selected per lane (1..16).
- MAX_PACK_LEN, 128, maximum digits per pack.
- LEN_W, $clog2(MAX_PACK_LEN+1), width of pack_len.
- LANE_W, (7*NUM_ACTIVE_BATTERIES+1)/2, binary width of one lane value (3.5 bits per digit, covers 10^K-1).
- SUM_W, 64, width of joltage_sum; arithmetic wraps modulo 2^SUM_W.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin batch; accepted only in IDLE.
- pack_len  in  [NUM_UNITS][LEN_W]  per-lane digit count, sampled when start is accepted.
- in_valid  in  1  digits beat valid.
- in_ready  out  1  engine accepts a beat (high only in STREAM).
- digits  in  [NUM_UNITS][4]  one BCD digit per lane per beat.
- result_valid  out  1  joltage_sum valid, held until accepted.
- result_ready  in  1  consumer accepts the result.
- joltage_sum  out  SUM_W  batch result.
- busy  out  1  high in any state other than IDLE.
- digit_err  out  1  sticky: a digit >9 was accepted this batch.

Behaviour:
- Reset (reset==0 at a clock edge): FSM goes to IDLE. in_ready=0, result_valid=0, joltage_sum=0, busy=0, digit_err=0, all lane stacks empty. Reset mid-batch aborts the batch and produces no result.
- FSM IDLE -> STREAM on start. Latch pack_len and compute L=max(pack_len). If L==0, go directly to CONVERT. digit_err clears on start.
- STREAM: in_ready=1. A beat transfers when in_valid&&in_ready. Beat counter b runs 0..L-1; after beat L-1 transfers, go to CONVERT. in_valid low stalls with no state change.
- Lane update per transferred beat, when b<pack_len[l], with d=digit:
  - Digit >9: treated as 0 and sets digit_err.
  - Remaining digits: rem = pack_len[l]-b. Lower slot bound lo = max(0, K-rem).
  - Find the first j in [lo, size] with j==size or stack[j]<d. If j<K, write stack[j]=d and set size=j+1; otherwise drop the digit.
  - This is a single-cycle parallel compare over K slots; no multi-cycle pops.
- Lanes with b>=pack_len[l] ignore the beat.
- Short packs: pack_len<K yields all digits in order (size=pack_len). pack_len==0 yields lane value 0.
- CONVERT: exactly K cycles. On each, every lane does acc = acc*10 + stack[i] for i<size, otherwise holds. Width is LANE_W, no overflow possible.
- REDUCE: binary adder tree, one register stage per level, S=$clog2(NUM_UNITS) cycles (minimum 1). Operands are zero-extended to SUM_W.
- DONE: joltage_sum updated, result_valid=1. It holds stable until result_valid&&result_ready, then goes to IDLE the same edge. start in DONE is ignored.
- Latency from last STREAM beat to result_valid: K+S+1 cycles.
- Lane stacks and accumulators clear on entry to STREAM, not on exit from DONE.

Optional Feature:
- Macro DAY3_RUNNING_TOTAL_EN.
- Defined: in DONE, joltage_sum <= joltage_sum + batch_sum, so it accumulates across batches modulo 2^SUM_W. Only reset clears it.
- Undefined: joltage_sum <= batch_sum, replaced each batch.

Test Plan:
- K=12, NUM_UNITS=4, packs 987654321111111 / 811111111111119 / 234234234234278 / 818181911112111, pack_len=15 -> joltage_sum=3121910778619 after 15 beats + 12+2+1 cycles.
- K=2, same packs -> lanes 98,89,78,92, joltage_sum=357.
- K=12, pack_len={15,5,0,15}, lane1 digits 31415, lanes 0/3 as first vector packs -> 987654321111+31415+0+434234234278=1421888586804. Beats beyond pack_len must be ignored.
- in_valid toggled 1-0-0-1 per cycle during STREAM and result_ready held low 5 cycles -> same sum as the unstalled case, result_valid and joltage_sum stable while stalled, digit_err=0.
- Digit 0xC injected in lane 2, then reset pulled low mid-CONVERT -> digit_err=1 before reset. After reset: busy=0, result_valid=0, joltage_sum=0. The next clean batch gives the correct sum.
- With DAY3_RUNNING_TOTAL_EN, two back-to-back K=2 batches of the packs above -> 357, then 714. Without the macro -> 357, then 357.
